// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared types and sizing helpers for the serial word feeder.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (appends an even-parity bit to each frame).
`default_nettype none

package serial_feeder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Counter must be able to hold WIDTH, the index of the parity bit when enabled.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_hold_reg.sv
// feeder_hold_reg: one-entry holding register that buffers the next word while a frame shifts out.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (no effect in this file).
`default_nettype none

module feeder_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             in_ready_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // A read only happens while full, when in_ready is low, so write and read never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en_i) begin
            data_q <= wr_data_i;
            full_q <= 1'b1;
        end else if (rd_en_i) begin
            full_q <= 1'b0;
        end
    end

    assign rd_data_o  = data_q;
    assign full_o     = full_q;
    assign in_ready_o = ~full_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: valid/ready parallel-to-serial stage emitting gapless one-bit frames.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (frame = WIDTH data bits + even parity bit).
`default_nettype none

module serial_word_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             FRAME_LEN = frame_len(WIDTH);
    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(FRAME_LEN - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             dout_valid_q;
    logic             word_done_q;
    logic             busy_q;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             parity_q;
`endif

    logic             accept;
    logic             last_bit;
    logic             load;
    logic             hold_wr;
    logic             hold_rd;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    cnt_nxt;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign hold_wr   = (state_q == SHIFT) && !last_bit && accept;
    assign hold_rd   = last_bit && hold_full;
    assign load      = ((state_q == IDLE) && accept) || (last_bit && (hold_full || accept));
    // hold_full is never set in IDLE, so this also covers the IDLE bypass.
    assign load_word = hold_full ? hold_data : in_data;
    assign cnt_nxt   = cnt_q + 1'b1;

    feeder_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (hold_wr),
        .wr_data_i  (in_data),
        .rd_en_i    (hold_rd),
        .rd_data_o  (hold_data),
        .full_o     (hold_full),
        .in_ready_o (in_ready)
    );

    // dout_q always carries the bit selected by cnt_q; sreg_q is pre-advanced to the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            dout_q       <= IDLE_LEVEL;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else if (load) begin
            state_q      <= SHIFT;
            sreg_q       <= advance(load_word);
            cnt_q        <= '0;
            dout_q       <= out_bit(load_word);
            dout_valid_q <= 1'b1;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q     <= ^load_word;
`endif
        end else if ((state_q == SHIFT) && !last_bit) begin
            sreg_q       <= advance(sreg_q);
            cnt_q        <= cnt_nxt;
            word_done_q  <= (cnt_nxt == LAST_CNT);
`ifdef SERIAL_FEEDER_PARITY_EN
            if (cnt_nxt == CW'(WIDTH))
                dout_q   <= parity_q;
            else
`endif
                dout_q   <= out_bit(sreg_q);
        end else if (last_bit) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            dout_q       <= IDLE_LEVEL;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: scoreboard bench driving an MSB-first and an LSB-first feeder in lockstep.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (model appends the even-parity bit).
`default_nettype none

module tb_serial_word_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    typedef struct {
        int cyc;
        bit b;
        bit done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [1:0] rdy, dout, dv, wd, busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        exp_t q[$];
        int   last_start = -1;
        int   last_end   = -1;

        serial_word_feeder #(
            .WIDTH      (8),
            .MSB_FIRST  (g == 0),
            .IDLE_LEVEL (1'b0)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .in_data    (in_data),
            .in_valid   (in_valid),
            .in_ready   (rdy[g]),
            .dout       (dout[g]),
            .dout_valid (dv[g]),
            .word_done  (wd[g]),
            .busy       (busy[g])
        );

        // Cycle k is the interval after clock edge k; a frame starts on the accept edge or right after the previous frame.
        always @(negedge clk) begin
            int   start;
            bit   ev;
            exp_t e;
            if (!reset) begin
                q.delete();
                last_start = -1;
                last_end   = -1;
                chk($sformatf("L%0d rst dout_valid", g), dv[g], 0);
                chk($sformatf("L%0d rst word_done", g), wd[g], 0);
                chk($sformatf("L%0d rst busy", g), busy[g], 0);
                chk($sformatf("L%0d rst in_ready", g), rdy[g], 1);
                chk($sformatf("L%0d rst dout", g), dout[g], 0);
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
                ev = (q.size() > 0) && (q[0].cyc == cyc);
                chk($sformatf("L%0d dout_valid", g), dv[g], ev);
                chk($sformatf("L%0d busy", g), busy[g], ev);
                chk($sformatf("L%0d in_ready", g), rdy[g], (last_start > cyc) ? 0 : 1);
                if (ev) begin
                    chk($sformatf("L%0d dout", g), dout[g], q[0].b);
                    chk($sformatf("L%0d word_done", g), wd[g], q[0].done);
                    void'(q.pop_front());
                end else begin
                    chk($sformatf("L%0d idle dout", g), dout[g], 0);
                    chk($sformatf("L%0d idle word_done", g), wd[g], 0);
                end
                if (in_valid && rdy[g]) begin
                    start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
                    for (int i = 0; i < FL; i++) begin
                        e.cyc  = start + i;
                        e.b    = (i < 8) ? ((in_data >> ((g == 0) ? 7 - i : i)) & 1) : ^in_data;
                        e.done = (i == FL - 1);
                        q.push_back(e);
                    end
                    last_start = start;
                    last_end   = start + FL - 1;
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] w);
        bit acc = 0;
        int t   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc) begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 50) begin
                chk("accept timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        send_word(8'h35);
        idle(12);
        send_word(8'h0F);
        send_word(8'hF0);
        idle(20);
        send_word(8'hAA);
        send_word(8'h55);
        send_word(8'hC3);
        idle(30);
        send_word(8'h01);
        idle(12);

        // Abort a frame on its bit 3 while a second word sits in the holding register.
        send_word(8'h96);
        send_word(8'h3C);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        send_word(8'h5A);
        idle(12);

        for (int k = 0; k < 150; k++) begin
            send_word(8'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
        end
        idle(40);
        chk("L0 drain", g_lane[0].q.size(), 0);
        chk("L1 drain", g_lane[1].q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
